// File: rtl/pipelined_rdca.sv
// Pipelined recursive-doubling carry adder (KGP prefix), valid/ready handshake.
// One operand set per cycle; the last doubling level is folded into the output stage.
module pipelined_rdca #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned LOG2W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_input,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam logic [1:0] Kill = 2'b00;
   localparam logic [1:0] Prop = 2'b01;
   localparam logic [1:0] Gen  = 2'b10;

   // One doubling level: a propagate at j inherits the value at j-d.
   function automatic logic [2*WIDTH-1:0] combine(input logic [2*WIDTH-1:0] k,
                                                  input int unsigned d);
      logic [2*WIDTH-1:0] r;
      r = k;
      for (int unsigned j = d; j < WIDTH; j++) begin
         if (k[2*j +: 2] == Prop) r[2*j +: 2] = k[2*(j-d) +: 2];
      end
      return r;
   endfunction

   logic               en;
   logic [WIDTH-1:0]   bp;
   logic               cin0;
   logic [2*WIDTH-1:0] kgp0;

   logic [2*WIDTH-1:0] kgp_q [LOG2W];
   logic [WIDTH-1:0]   a_q   [LOG2W];
   logic [WIDTH-1:0]   bp_q  [LOG2W];
   logic               cin_q [LOG2W];
   logic               sub_q [LOG2W];
   logic               vld_q [LOG2W];

   logic               out_valid_q;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;
   logic [2*WIDTH-1:0] kfin;
   logic [WIDTH:0]     c;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   assign bp   = sub ? ~b : b;
   assign cin0 = sub | c_input;

   // Bit 0 absorbs the carry-in, so it is never propagate.
   always_comb begin
      kgp0 = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i == 0) begin
            kgp0[1:0] = ((a[0] & bp[0]) | ((a[0] ^ bp[0]) & cin0)) ? Gen : Kill;
         end else if (a[i] & bp[i]) begin
            kgp0[2*i +: 2] = Gen;
         end else if (a[i] ^ bp[i]) begin
            kgp0[2*i +: 2] = Prop;
         end else begin
            kgp0[2*i +: 2] = Kill;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         kgp_q[0] <= kgp0;
         a_q[0]   <= a;
         bp_q[0]  <= bp;
         cin_q[0] <= c_input;
         sub_q[0] <= sub;
         for (int unsigned l = 1; l < LOG2W; l++) begin
            kgp_q[l] <= combine(kgp_q[l-1], 32'd1 << (l - 1));
            a_q[l]   <= a_q[l-1];
            bp_q[l]  <= bp_q[l-1];
            cin_q[l] <= cin_q[l-1];
            sub_q[l] <= sub_q[l-1];
         end
      end
   end

   always_comb begin
      kfin = combine(kgp_q[LOG2W-1], WIDTH / 2);
      c    = '0;
      c[0] = sub_q[LOG2W-1] | cin_q[LOG2W-1];
      for (int i = 0; i < int'(WIDTH); i++) begin
         c[i+1] = (kfin[2*i +: 2] == Gen);
      end
      sum_d   = a_q[LOG2W-1] ^ bp_q[LOG2W-1] ^ c[WIDTH-1:0];
      carry_d = c[WIDTH];
      ovf_d   = (a_q[LOG2W-1][WIDTH-1] == bp_q[LOG2W-1][WIDTH-1]) &&
                (sum_d[WIDTH-1] != a_q[LOG2W-1][WIDTH-1]);
      zero_d  = (sum_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned l = 0; l < LOG2W; l++) vld_q[l] <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else if (en) begin
         vld_q[0] <= in_valid;
         for (int unsigned l = 1; l < LOG2W; l++) vld_q[l] <= vld_q[l-1];
         out_valid_q <= vld_q[LOG2W-1];
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_rdca.sv
// Bench for pipelined_rdca: 64-bit and 8-bit instances checked against a scoreboard.
module tb_pipelined_rdca;

   localparam int LAT64 = 7;
   localparam int LAT8  = 4;

   typedef struct {
      logic [63:0] sum;
      logic        carry;
      logic        ovf;
      logic        zero;
      int          k;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid64, in_ready64, c_in64, sub64, out_valid64, out_ready64;
   logic [63:0] a64, b64, sum64;
   logic        carry64, ovf64, zero64;
   logic        in_valid8, in_ready8, c_in8, sub8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, sum8;
   logic        carry8, ovf8, zero8;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   acc64 = 0;
   logic lat_on = 1'b0;
   exp_t nxt64, nxt8;
   exp_t q64[$];
   exp_t q8[$];

   pipelined_rdca #(.WIDTH(64)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
      .a(a64), .b(b64), .c_input(c_in64), .sub(sub64),
      .out_valid(out_valid64), .out_ready(out_ready64), .sum(sum64),
      .carry(carry64), .overflow(ovf64), .zero(zero64)
   );

   pipelined_rdca #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .c_input(c_in8), .sub(sub8),
      .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
      .carry(carry8), .overflow(ovf8), .zero(zero8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model64(input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic s);
      exp_t        e;
      logic [63:0] bp;
      logic [64:0] r;
      logic [65:0] sv;
      bp = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, bp} + {64'd0, (s | cin)};
      sv = {{2{a[63]}}, a} + {{2{bp[63]}}, bp} + {65'd0, (s | cin)};
      e.sum   = r[63:0];
      e.carry = r[64];
      e.ovf   = (sv[64] != sv[63]);
      e.zero  = (r[63:0] == 64'd0);
      e.k     = 0;
      return e;
   endfunction

   function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic s);
      exp_t       e;
      logic [7:0] bp;
      logic [8:0] r;
      logic [9:0] sv;
      bp = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, bp} + {8'd0, (s | cin)};
      sv = {{2{a[7]}}, a} + {{2{bp[7]}}, bp} + {9'd0, (s | cin)};
      e.sum   = {56'd0, r[7:0]};
      e.carry = r[8];
      e.ovf   = (sv[8] != sv[7]);
      e.zero  = (r[7:0] == 8'd0);
      e.k     = 0;
      return e;
   endfunction

   // Score outputs at the falling edge, then advance past the next rising edge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (rst) begin
         q64.delete();
         q8.delete();
      end else begin
         if (out_valid64) begin
            check("pend64", {63'd0, q64.size() != 0}, 64'd1);
            if (q64.size() != 0) begin
               e = q64[0];
               check("sum64", sum64, e.sum);
               check("carry64", {63'd0, carry64}, {63'd0, e.carry});
               check("ovf64", {63'd0, ovf64}, {63'd0, e.ovf});
               check("zero64", {63'd0, zero64}, {63'd0, e.zero});
               if (lat_on) check("lat64", 64'(cyc - e.k), 64'(LAT64));
               if (out_ready64) void'(q64.pop_front());
            end
         end
         if (out_valid8) begin
            check("pend8", {63'd0, q8.size() != 0}, 64'd1);
            if (q8.size() != 0) begin
               e = q8[0];
               check("res8", {55'd0, carry8, sum8}, {55'd0, e.carry, e.sum[7:0]});
               check("ovf8", {62'd0, ovf8, zero8}, {62'd0, e.ovf, e.zero});
               check("lat8", 64'(cyc - e.k), 64'(LAT8));
               if (out_ready8) void'(q8.pop_front());
            end
         end
         if (in_valid64 && in_ready64) begin
            e = nxt64;
            e.k = cyc;
            q64.push_back(e);
            acc64++;
         end
         if (in_valid8 && in_ready8) begin
            e = nxt8;
            e.k = cyc;
            q8.push_back(e);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drive64(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic s, input exp_t e);
      a64 = a;  b64 = b;  c_in64 = cin;  sub64 = s;  in_valid64 = 1'b1;
      nxt64 = e;
   endtask

   task automatic drain();
      int n = 0;
      while ((q64.size() != 0 || q8.size() != 0) && n < 300) begin
         cycle();
         n++;
      end
      check("drain64", 64'(q64.size()), 64'd0);
      check("drain8", 64'(q8.size()), 64'd0);
   endtask

   // Directed op with hand-computed result, out_ready held high.
   task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic s, input logic [63:0] esum, input logic ec,
                       input logic eo, input logic ez);
      exp_t e;
      e.sum = esum;  e.carry = ec;  e.ovf = eo;  e.zero = ez;  e.k = 0;
      drive64(a, b, cin, s, e);
      cycle();
      in_valid64 = 1'b0;
      drain();
   endtask

   task automatic rand64();
      logic [63:0] a, b;
      logic        cin, s;
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      drive64(a, b, cin, s, model64(a, b, cin, s));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid64 = 1'b0;  out_ready64 = 1'b0;  a64 = '0;  b64 = '0;  c_in64 = 1'b0;
      sub64 = 1'b0;
      in_valid8 = 1'b0;   out_ready8 = 1'b1;   a8 = '0;   b8 = '0;   c_in8 = 1'b0;
      sub8 = 1'b0;
      nxt64 = model64('0, '0, 1'b0, 1'b0);
      nxt8  = model8('0, '0, 1'b0, 1'b0);
      cycle();
      cycle();
      check("rst_ov64", {63'd0, out_valid64}, 64'd0);
      check("rst_sum64", sum64, 64'd0);
      check("rst_flags64", {61'd0, carry64, ovf64, zero64}, 64'd0);
      check("rst_ov8", {63'd0, out_valid8}, 64'd0);
      rst = 1'b0;
      #1;
      check("rst_rdy64", {63'd0, in_ready64}, 64'd1);
      check("rst_rdy8", {63'd0, in_ready8}, 64'd1);
      out_ready64 = 1'b1;
      lat_on = 1'b1;

      op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      op64(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      op64(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
      op64(64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
      op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
      op64(64'd0, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
      op64(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
           64'h2345_6789_ABCD_F002, 1'b0, 1'b0, 1'b0);

      // Random stream under pseudo-random back-pressure.
      lat_on = 1'b0;
      acc64 = 0;
      for (int n = 0; n < 1000 && acc64 < 20; n++) begin
         out_ready64 = 1'($urandom_range(0, 1));
         rand64();
         in_valid64 = ($urandom_range(0, 3) != 0);
         cycle();
      end
      check("acc20", 64'(acc64), 64'd20);
      in_valid64 = 1'b0;
      out_ready64 = 1'b1;
      drain();

      // Back-to-back full throughput.
      lat_on = 1'b1;
      for (int i = 0; i < 100; i++) begin
         rand64();
         cycle();
         check("tput_ov", {63'd0, out_valid64}, {63'd0, (i + 1 >= LAT64)});
      end
      in_valid64 = 1'b0;
      drain();

      // Reset with three operations in flight; an operand offered during reset is dropped.
      for (int i = 0; i < 3; i++) begin
         rand64();
         cycle();
      end
      rand64();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      in_valid64 = 1'b0;
      #1;
      check("mid_rdy", {63'd0, in_ready64}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("mid_ov", {63'd0, out_valid64}, 64'd0);
      end

      // WIDTH=8 sweep: every a, strided b, all three modes, streamed back-to-back.
      for (int ia = 0; ia < 256; ia++) begin
         for (int ib = 0; ib < 256; ib += 17) begin
            for (int m = 0; m < 3; m++) begin
               a8 = 8'(ia);
               b8 = 8'(ib);
               c_in8 = (m == 1);
               sub8  = (m == 2);
               in_valid8 = 1'b1;
               nxt8 = model8(a8, b8, c_in8, sub8);
               cycle();
            end
         end
      end
      in_valid8 = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
